// File: rtl/dmem_copy_engine.sv
// Memory-port initiator that copies or fills blocks of 32-bit words without CPU help.
// Reports done/err pulses and a running modulo-2^32 sum of the words it wrote.
module dmem_copy_engine #(
    parameter int RAM_SIZE = 256,
    parameter int LEN_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      sum,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [31:0]      data_reg;
    logic [LEN_W-1:0] count;
    logic             err_flag;
    logic             mode_reg;
    logic [33:0]      span;
    logic [33:0]      src_end;
    logic [33:0]      dst_end;
    logic             param_err;

    // End addresses use 34 bits so a large base plus length cannot wrap past the bound.
    always_comb begin
        span      = 34'(len) << 2;
        src_end   = {2'b00, src_addr} + span;
        dst_end   = {2'b00, dst_addr} + span;
        param_err = (dst_addr[1:0] != 2'b00) || (dst_end > 34'(RAM_SIZE)) ||
                    (!mode && ((src_addr[1:0] != 2'b00) || (src_end > 34'(RAM_SIZE))));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        err        = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (param_err || (len == '0)) begin
                        next_state = FIN;
                    end else if (mode) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD: begin
                mem_rd     = 1'b1;
                mem_addr   = src_ptr;
                next_state = WR;
            end
            WR: begin
                mem_wr    = 1'b1;
                mem_addr  = dst_ptr;
                mem_wdata = data_reg;
                // The word being written now is the last one when one word remains.
                if (count == LEN_W'(1)) begin
                    next_state = FIN;
                end else if (mode_reg) begin
                    next_state = WR;
                end else begin
                    next_state = RD;
                end
            end
            FIN: begin
                done       = 1'b1;
                err        = err_flag;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ptr  <= 32'h0;
            dst_ptr  <= 32'h0;
            data_reg <= 32'h0;
            count    <= '0;
            err_flag <= 1'b0;
            mode_reg <= 1'b0;
            sum      <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr  <= src_addr;
                        dst_ptr  <= dst_addr;
                        data_reg <= fill_data;
                        count    <= len;
                        err_flag <= param_err;
                        mode_reg <= mode;
                        sum      <= 32'h0;
                    end
                end
                RD: begin
                    data_reg <= mem_rdata;
                    src_ptr  <= src_ptr + 32'd4;
                end
                WR: begin
                    dst_ptr <= dst_ptr + 32'd4;
                    sum     <= sum + data_reg;
                    count   <= count - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
